// File: rtl/seg7_if.sv
// seg7_if: value load, display options, status and segment-bus signals of the 7-segment driver
interface seg7_if #(parameter int VALUE_W = 14, parameter int SEL_W = 3);
  logic               load;
  logic [VALUE_W-1:0] value;
  logic               blank_lz;
  logic               dp_en;
  logic [SEL_W-1:0]   dp_pos;
  logic               busy;
  logic               overflow;
  logic               en_o;
  logic [SEL_W-1:0]   dig_sel;
  logic [7:0]         dig_num;
  modport master (output load, value, blank_lz, dp_en, dp_pos,
                  input busy, overflow, en_o, dig_sel, dig_num);
  modport slave (input load, value, blank_lz, dp_en, dp_pos,
                 output busy, overflow, en_o, dig_sel, dig_num);
endinterface

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: double-dabble binary-to-BCD plus multiplexed active-low 7-segment scan driver
module seg7_scan_display #(
  parameter int DIGITS   = 4,
  parameter int VALUE_W  = 14,
  parameter int SCAN_DIV = 131072,
  parameter int SEL_W    = 3
) (
  input logic  clk,
  input logic  rst_n,
  seg7_if.slave bus
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(VALUE_W + 1);
  localparam int PW = $clog2(SCAN_DIV);
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [VALUE_W-1:0] shift_q, shift_d;
  logic [BW-1:0]      work_q, work_d, adj, disp_q;
  logic               sticky_q, ovf_q, en_q;
  logic [PW-1:0]      pre_q;
  logic [SEL_W-1:0]   sel_q;
  logic [7:0]         seg_q, seg_d;
  logic               do_load, do_shift, do_commit, last, wrap;
  logic [3:0]         nib;
  logic               lz, keep, dp;
  function automatic logic [6:0] dec(input logic [3:0] n);
    case (n)
      4'd0: dec = 7'b0000001;
      4'd1: dec = 7'b1001111;
      4'd2: dec = 7'b0010010;
      4'd3: dec = 7'b0000110;
      4'd4: dec = 7'b1001100;
      4'd5: dec = 7'b0100100;
      4'd6: dec = 7'b0100000;
      4'd7: dec = 7'b0001111;
      4'd8: dec = 7'b0000000;
      4'd9: dec = 7'b0000100;
      default: dec = 7'b1111111;
    endcase
  endfunction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  assign last = cnt_q == CW'(VALUE_W - 1);
  always_comb
    state_d = state_q == IDLE  ? (bus.load ? SHIFT : IDLE) :
              state_q == SHIFT ? (last ? COMMIT : SHIFT) : IDLE;
  always_comb begin
    do_load   = state_q == IDLE && bus.load;
    do_shift  = state_q == SHIFT;
    do_commit = state_q == COMMIT;
    bus.busy  = state_q != IDLE;
  end
  always_comb begin
    adj = work_q;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = work_q[4*i +: 4] >= 4'd5 ? work_q[4*i +: 4] + 4'd3 : work_q[4*i +: 4];
    {work_d, shift_d} = {adj, shift_q} << 1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q    <= '0;
      shift_q  <= '0;
      work_q   <= '0;
      sticky_q <= 1'b0;
      disp_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_load) begin
        shift_q  <= bus.value;
        work_q   <= '0;
        sticky_q <= 1'b0;
        cnt_q    <= '0;
      end
      if (do_shift) begin
        shift_q  <= shift_d;
        work_q   <= work_d;
        sticky_q <= sticky_q | adj[BW-1];
        cnt_q    <= cnt_q + 1'b1;
      end
      if (do_commit) begin
        disp_q <= work_q;
        ovf_q  <= sticky_q;
      end
    end
  assign wrap = pre_q == PW'(SCAN_DIV - 1);
  // A zero at or right of the decimal point stays visible so fractions read as 0.05
  always_comb begin
    nib   = disp_q[4*sel_q +: 4];
    lz    = (disp_q >> (4 * sel_q)) == '0;
    keep  = sel_q == '0 || (bus.dp_en && sel_q <= bus.dp_pos);
    dp    = bus.dp_en && sel_q == bus.dp_pos;
    seg_d = {ovf_q ? 7'b1111110 : (bus.blank_lz && lz && !keep) ? 7'b1111111 : dec(nib), ~dp};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pre_q <= '0;
      sel_q <= '0;
      en_q  <= 1'b0;
      seg_q <= 8'hFF;
    end else begin
      pre_q <= wrap ? '0 : pre_q + 1'b1;
      if (wrap) sel_q <= sel_q == SEL_W'(DIGITS - 1) ? '0 : sel_q + 1'b1;
      en_q  <= 1'b1;
      seg_q <= seg_d;
    end
  assign bus.overflow = ovf_q;
  assign bus.en_o     = en_q;
  assign bus.dig_sel  = sel_q;
  assign bus.dig_num  = seg_q;
endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
Parametrised multiplexed 7-segment driver for the ADC board display.
- Accepts a binary value through a load strobe.
- Converts it to BCD with a sequential double-dabble engine, one bit per cycle.
- Time-multiplexes DIGITS digits, with optional leading-zero blanking, a decimal point and an overflow indication.
- Drives the board digit-select decoder and the shared active-low segment bus directly.

Parameters:
DIGITS, 4, number of scanned digits (1..8).
VALUE_W, 14, width of the binary input value (1..27).
SCAN_DIV, 131072, clk cycles each digit stays selected (>=2).
SEL_W, 3, width of dig_sel (2^SEL_W >= DIGITS).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
load  in  1  single-cycle strobe; capture value, start conversion
value  in  VALUE_W  unsigned binary value to display
blank_lz  in  1  1 = blank leading zeros; sampled every scan step
dp_en  in  1  1 = light the decimal point on digit dp_pos
dp_pos  in  SEL_W  digit index carrying the decimal point (0 = least significant)
busy  out  1  conversion in progress; load is ignored while high
overflow  out  1  displayed value >= 10^DIGITS
en_o  out  1  display enable; constant 1 after reset
dig_sel  out  SEL_W  index of the currently driven digit
dig_num  out  8  segments {a,b,c,d,e,f,g,dp}, active-low (0 = lit)

Behaviour:
- Reset (async, rst_n=0):
  - busy=0, overflow=0, dig_sel=0, dig_num=8'hFF, en_o=0.
  - Display BCD register cleared to 0. Prescaler cleared. FSM in IDLE.
  - en_o goes to 1 on the first clk edge after release.
- FSM states: IDLE, SHIFT, COMMIT.
  - IDLE: on load=1, capture value into the shift register, clear the work BCD register and the overflow sticky, set busy=1, go to SHIFT.
  - SHIFT: runs exactly VALUE_W cycles.
    - Each cycle, first add 3 to every work BCD nibble >= 5.
    - Then shift {work_bcd, shift_reg} left by 1.
    - A 1 shifted out of the top nibble's MSB sets the overflow sticky.
  - COMMIT (1 cycle): copy work BCD into the display BCD register, copy the sticky to overflow, set busy=0, return to IDLE.
- Latency: load sampled on edge N; the new digits and overflow are visible from edge N+VALUE_W+2.
- load while busy=1 is ignored; no queuing.
- load in the same cycle as COMMIT is ignored. load one cycle later is accepted.
- Display BCD holds its last committed value between loads.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1 and wraps.
  - On wrap, dig_sel increments; DIGITS-1 wraps to 0.
  - dig_sel never takes values >= DIGITS.
- dig_num is registered and is updated on every clk edge from the current dig_sel (one-cycle lag after a dig_sel change).
- Segment codes (active-low):
  - 0=00000011, 1=10011111, 2=00100101, 3=00001101, 4=10011001, 5=01001001, 6=01000001, 7=00011111, 8=00000001, 9=00001001.
  - Blank=11111111. Dash=11111101.
- Digit content priority:
  1. overflow=1: every digit shows dash.
  2. Otherwise, if blank_lz=1 and the digit is a leading zero (this nibble and all higher nibbles are 0) and the index is not 0, the digit is blank.
  3. Otherwise the nibble's decimal code.
- Decimal point:
  - When dp_en=1 and dig_sel==dp_pos, dig_num[0]=0, including on blank and dash digits.
  - A leading-zero digit at index <= dp_pos is never blanked, so 0.05 displays correctly.
- Reset mid-conversion aborts it; the display returns to the reset state (all digits 0).

Test Plan:
1. Reset -> dig_num=8'hFF, dig_sel=0, busy=0, overflow=0. After release, en_o=1 and the display shows 0000 with blank_lz=0.
2. SCAN_DIV=4: check dig_sel sequence 0,1,2,3,0 with each value held 4 cycles. Load 1234 -> busy high for 15 cycles; digit3..0 = 10011111, 00100101, 00001101, 10011001.
3. blank_lz=1, load 7 -> digits 3..1 = 11111111, digit0 = 00011111. Repeat with dp_en=1, dp_pos=2 -> digits 2,1 show 00000010, 00000011 (i.e. "0.07").
4. Load 16383 (VALUE_W=14) -> overflow=1 and all digits 11111101. Then load 9999 -> overflow=0 and all digits 00001001.
5. Load 4321, and pulse load with 1111 while busy=1 -> display shows 4321. A load one cycle after busy falls is accepted.
6. Assert rst_n=0 during SHIFT after loading 5555 -> busy=0 and display 0000 after release. A subsequent load of 42 completes normally.
